// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: independent write (AW/W/B) and read (AR/R) engines over a
// 2^(ADDR_WIDTH-2)-word array, with FIXED/INCR/WRAP bursts, byte strobes and SLVERR handling.
module axi_mem_slave #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   io_AW_ADDR,
    input  logic [7:0]              io_AW_LEN,
    input  logic [2:0]              io_AW_SIZE,
    input  logic [1:0]              io_AW_BURST,
    input  logic [ID_WIDTH-1:0]     io_AW_ID,
    input  logic [2:0]              io_AW_PROT,
    input  logic                    io_AW_VALID,
    output logic                    io_AW_READY,
    input  logic [DATA_WIDTH-1:0]   io_W_DATA,
    input  logic [DATA_WIDTH/8-1:0] io_W_STRB,
    input  logic                    io_W_LAST,
    input  logic                    io_W_VALID,
    output logic                    io_W_READY,
    output logic [ID_WIDTH-1:0]     io_B_ID,
    output logic                    io_B_RESP,
    output logic                    io_B_VALID,
    input  logic                    io_B_READY,
    input  logic [ADDR_WIDTH-1:0]   io_AR_ADDR,
    input  logic [7:0]              io_AR_LEN,
    input  logic [2:0]              io_AR_SIZE,
    input  logic [1:0]              io_AR_BURST,
    input  logic [ID_WIDTH-1:0]     io_AR_ID,
    input  logic [2:0]              io_AR_PROT,
    input  logic                    io_AR_VALID,
    output logic                    io_AR_READY,
    output logic [DATA_WIDTH-1:0]   io_R_DATA,
    output logic [ID_WIDTH-1:0]     io_R_ID,
    output logic                    io_R_RESP,
    output logic                    io_R_LAST,
    output logic                    io_R_VALID,
    input  logic                    io_R_READY
);
    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_t;
    typedef enum logic {RIDLE, RDATA} rstate_t;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [15:0] step, mask, a16, sum, wrapped;
        step    = 16'd1 << size;
        mask    = (({8'd0, len} + 16'd1) * step) - 16'd1;
        a16     = 16'(addr);
        sum     = a16 + step;
        wrapped = (a16 & ~mask) | (sum & mask);
        case (burst)
            2'd1:    next_addr = sum[ADDR_WIDTH-1:0];
            2'd2:    next_addr = wrapped[ADDR_WIDTH-1:0];
            default: next_addr = addr;
        endcase
    endfunction

    function automatic logic req_err(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [15:0] align_mask;
        logic        bad_len;
        align_mask = (16'd1 << size) - 16'd1;
        bad_len    = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        req_err    = (size > 3'd2) || (burst == 2'd3) ||
                     ((burst == 2'd2) && (bad_len || ((16'(addr) & align_mask) != 16'd0)));
    endfunction

    logic unused_prot;
    assign unused_prot = ^{io_AW_PROT, io_AR_PROT};

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    // Write engine
    wstate_t               wstate_q, wstate_d;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [7:0]            wlen_q, wcnt_q;
    logic [2:0]            wsize_q;
    logic [1:0]            wburst_q;
    logic [ID_WIDTH-1:0]   wid_q;
    logic                  werr_q;
    logic                  aw_fire, w_fire, w_last_beat, w_beat_err;

    assign aw_fire     = io_AW_VALID && io_AW_READY;
    assign w_fire      = io_W_VALID && io_W_READY;
    assign w_last_beat = (wcnt_q == wlen_q);
    // A beat whose LAST flag disagrees with the counter poisons the rest of the burst.
    assign w_beat_err  = werr_q || (io_W_LAST != w_last_beat);

    always_comb begin
        wstate_d    = wstate_q;
        io_AW_READY = 1'b0;
        io_W_READY  = 1'b0;
        io_B_VALID  = 1'b0;
        case (wstate_q)
            WIDLE: begin
                io_AW_READY = 1'b1;
                if (io_AW_VALID) wstate_d = WDATA;
            end
            WDATA: begin
                io_W_READY = 1'b1;
                if (io_W_VALID && w_last_beat) wstate_d = WRESP;
            end
            WRESP: begin
                io_B_VALID = 1'b1;
                if (io_B_READY) wstate_d = WIDLE;
            end
            default: wstate_d = WIDLE;
        endcase
    end

    assign io_B_RESP = (wstate_q == WRESP) && werr_q;
    assign io_B_ID   = wid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wstate_q <= WIDLE;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wsize_q  <= '0;
            wburst_q <= '0;
            wid_q    <= '0;
            werr_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            if (aw_fire) begin
                waddr_q  <= io_AW_ADDR;
                wlen_q   <= io_AW_LEN;
                wsize_q  <= io_AW_SIZE;
                wburst_q <= io_AW_BURST;
                wid_q    <= io_AW_ID;
                wcnt_q   <= 8'd0;
                werr_q   <= req_err(io_AW_ADDR, io_AW_LEN, io_AW_SIZE, io_AW_BURST);
            end else if (w_fire) begin
                waddr_q <= next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                wcnt_q  <= wcnt_q + 8'd1;
                werr_q  <= w_beat_err;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else if (w_fire && !w_beat_err) begin
            for (int b = 0; b < LANES; b++) begin
                if (io_W_STRB[b]) mem_q[waddr_q[ADDR_WIDTH-1:2]][8*b +: 8] <= io_W_DATA[8*b +: 8];
            end
        end
    end

    // Read engine
    rstate_t               rstate_q, rstate_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_nxt;
    logic [7:0]            rlen_q, rcnt_q;
    logic [2:0]            rsize_q;
    logic [1:0]            rburst_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic                  rerr_q, ar_err;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ar_fire, r_fire, r_last_beat;

    assign ar_fire     = io_AR_VALID && io_AR_READY;
    assign r_fire      = io_R_VALID && io_R_READY;
    assign r_last_beat = (rcnt_q == rlen_q);
    assign raddr_nxt   = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
    assign ar_err      = req_err(io_AR_ADDR, io_AR_LEN, io_AR_SIZE, io_AR_BURST);

    always_comb begin
        rstate_d    = rstate_q;
        io_AR_READY = 1'b0;
        io_R_VALID  = 1'b0;
        case (rstate_q)
            RIDLE: begin
                io_AR_READY = 1'b1;
                if (io_AR_VALID) rstate_d = RDATA;
            end
            RDATA: begin
                io_R_VALID = 1'b1;
                if (io_R_READY && r_last_beat) rstate_d = RIDLE;
            end
            default: rstate_d = RIDLE;
        endcase
    end

    assign io_R_DATA = rdata_q;
    assign io_R_ID   = rid_q;
    assign io_R_LAST = (rstate_q == RDATA) && r_last_beat;
    assign io_R_RESP = (rstate_q == RDATA) && rerr_q;

    // Data is prefetched into rdata_q so R_DATA is registered and stable under backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            rstate_q <= RIDLE;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rid_q    <= '0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rstate_q <= rstate_d;
            if (ar_fire) begin
                raddr_q  <= io_AR_ADDR;
                rlen_q   <= io_AR_LEN;
                rsize_q  <= io_AR_SIZE;
                rburst_q <= io_AR_BURST;
                rid_q    <= io_AR_ID;
                rcnt_q   <= 8'd0;
                rerr_q   <= ar_err;
                rdata_q  <= ar_err ? '0 : mem_q[io_AR_ADDR[ADDR_WIDTH-1:2]];
            end else if (r_fire && !r_last_beat) begin
                raddr_q <= raddr_nxt;
                rcnt_q  <= rcnt_q + 8'd1;
                rdata_q <= rerr_q ? '0 : mem_q[raddr_nxt[ADDR_WIDTH-1:2]];
            end
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: write/read bursts, strobes, errors, backpressure, reset.
module tb_axi_mem_slave;
    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  io_AW_ADDR, io_AR_ADDR;
    logic [7:0]  io_AW_LEN, io_AR_LEN;
    logic [2:0]  io_AW_SIZE, io_AR_SIZE, io_AW_PROT, io_AR_PROT;
    logic [1:0]  io_AW_BURST, io_AR_BURST;
    logic        io_AW_ID, io_AR_ID, io_AW_VALID, io_AR_VALID, io_AW_READY, io_AR_READY;
    logic [31:0] io_W_DATA, io_R_DATA;
    logic [3:0]  io_W_STRB;
    logic        io_W_LAST, io_W_VALID, io_W_READY;
    logic        io_B_ID, io_B_RESP, io_B_VALID, io_B_READY;
    logic        io_R_ID, io_R_RESP, io_R_LAST, io_R_VALID, io_R_READY;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] wdata_v [16];
    logic [3:0]  wstrb_v [16];
    logic [31:0] rdata_v [16];
    logic        rlast_v [16];
    logic        rresp_v [16];
    logic        bresp;

    always #5 clock = ~clock;

    axi_mem_slave #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .ID_WIDTH(1)) dut (
        .clock(clock), .reset(reset),
        .io_AW_ADDR(io_AW_ADDR), .io_AW_LEN(io_AW_LEN), .io_AW_SIZE(io_AW_SIZE),
        .io_AW_BURST(io_AW_BURST), .io_AW_ID(io_AW_ID), .io_AW_PROT(io_AW_PROT),
        .io_AW_VALID(io_AW_VALID), .io_AW_READY(io_AW_READY),
        .io_W_DATA(io_W_DATA), .io_W_STRB(io_W_STRB), .io_W_LAST(io_W_LAST),
        .io_W_VALID(io_W_VALID), .io_W_READY(io_W_READY),
        .io_B_ID(io_B_ID), .io_B_RESP(io_B_RESP), .io_B_VALID(io_B_VALID), .io_B_READY(io_B_READY),
        .io_AR_ADDR(io_AR_ADDR), .io_AR_LEN(io_AR_LEN), .io_AR_SIZE(io_AR_SIZE),
        .io_AR_BURST(io_AR_BURST), .io_AR_ID(io_AR_ID), .io_AR_PROT(io_AR_PROT),
        .io_AR_VALID(io_AR_VALID), .io_AR_READY(io_AR_READY),
        .io_R_DATA(io_R_DATA), .io_R_ID(io_R_ID), .io_R_RESP(io_R_RESP), .io_R_LAST(io_R_LAST),
        .io_R_VALID(io_R_VALID), .io_R_READY(io_R_READY)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, input logic id, input bit early, output logic resp);
        int n;
        io_AW_ADDR = a; io_AW_LEN = l; io_AW_SIZE = s; io_AW_BURST = b; io_AW_ID = id;
        io_AW_VALID = 1'b1;
        step();
        io_AW_VALID = 1'b0;
        check("aw_ready_busy", 32'(io_AW_READY), 32'd0);
        for (int i = 0; i <= int'(l); i++) begin
            check("w_ready", 32'(io_W_READY), 32'd1);
            io_W_DATA  = wdata_v[i];
            io_W_STRB  = wstrb_v[i];
            io_W_LAST  = (i == int'(l)) || (early && i == 0);
            io_W_VALID = 1'b1;
            step();
        end
        io_W_VALID = 1'b0;
        io_W_LAST  = 1'b0;
        n = 0;
        while (!io_B_VALID && n < 20) begin
            step();
            n++;
        end
        check("b_latency", 32'(n), 32'd0);
        check("b_id", 32'(io_B_ID), 32'(id));
        resp = io_B_RESP;
        io_B_READY = 1'b1;
        step();
        io_B_READY = 1'b0;
        check("aw_ready_idle", 32'(io_AW_READY), 32'd1);
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] b, input logic id, input bit bp);
        int          beat, cyc;
        logic        stalled;
        logic [31:0] held;
        io_AR_ADDR = a; io_AR_LEN = l; io_AR_SIZE = s; io_AR_BURST = b; io_AR_ID = id;
        io_AR_VALID = 1'b1;
        step();
        io_AR_VALID = 1'b0;
        check("r_valid_first", 32'(io_R_VALID), 32'd1);
        check("r_id", 32'(io_R_ID), 32'(id));
        beat = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (beat <= int'(l) && cyc < 64) begin
            if (stalled) check("r_hold", io_R_DATA, held);
            io_R_READY = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (io_R_READY && io_R_VALID) begin
                rdata_v[beat] = io_R_DATA;
                rlast_v[beat] = io_R_LAST;
                rresp_v[beat] = io_R_RESP;
                beat++;
            end
            stalled = !io_R_READY;
            held    = io_R_DATA;
            step();
            cyc++;
        end
        io_R_READY = 1'b0;
        check("r_beats", 32'(beat), 32'(l) + 32'd1);
        check("r_valid_done", 32'(io_R_VALID), 32'd0);
        check("ar_ready_idle", 32'(io_AR_READY), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_aw_ready"}, 32'(io_AW_READY), 32'd1);
        check({tag, "_ar_ready"}, 32'(io_AR_READY), 32'd1);
        check({tag, "_w_ready"}, 32'(io_W_READY), 32'd0);
        check({tag, "_b_valid"}, 32'(io_B_VALID), 32'd0);
        check({tag, "_b_resp"}, 32'(io_B_RESP), 32'd0);
        check({tag, "_b_id"}, 32'(io_B_ID), 32'd0);
        check({tag, "_r_valid"}, 32'(io_R_VALID), 32'd0);
        check({tag, "_r_last"}, 32'(io_R_LAST), 32'd0);
        check({tag, "_r_resp"}, 32'(io_R_RESP), 32'd0);
        check({tag, "_r_id"}, 32'(io_R_ID), 32'd0);
        check({tag, "_r_data"}, io_R_DATA, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        io_AW_ADDR = '0; io_AW_LEN = '0; io_AW_SIZE = '0; io_AW_BURST = '0; io_AW_ID = '0;
        io_AW_PROT = '0; io_AW_VALID = 1'b0;
        io_AR_ADDR = '0; io_AR_LEN = '0; io_AR_SIZE = '0; io_AR_BURST = '0; io_AR_ID = '0;
        io_AR_PROT = '0; io_AR_VALID = 1'b0;
        io_W_DATA = '0; io_W_STRB = '0; io_W_LAST = 1'b0; io_W_VALID = 1'b0;
        io_B_READY = 1'b0; io_R_READY = 1'b0;
        for (int i = 0; i < 16; i++) begin wdata_v[i] = '0; wstrb_v[i] = 4'hF; end
        step(); step();
        check_reset_outputs("rst0");
        reset = 1'b0;
        step();

        // single write then read
        wdata_v[0] = 32'h07563314;
        axi_write(6'h38, 8'd0, 3'd2, 2'd1, 1'b1, 1'b0, bresp);
        check("single_bresp", 32'(bresp), 32'd0);
        axi_read(6'h38, 8'd0, 3'd2, 2'd1, 1'b0, 1'b0);
        check("single_rdata", rdata_v[0], 32'h07563314);
        check("single_rlast", 32'(rlast_v[0]), 32'd1);
        check("single_rresp", 32'(rresp_v[0]), 32'd0);

        // INCR wrapping 0x3C -> 0x00
        wdata_v[0] = 32'hAAAA0001; wdata_v[1] = 32'hBBBB0002;
        axi_write(6'h3C, 8'd1, 3'd2, 2'd1, 1'b0, 1'b0, bresp);
        check("incrwrap_bresp", 32'(bresp), 32'd0);
        axi_read(6'h3C, 8'd1, 3'd2, 2'd1, 1'b1, 1'b0);
        check("incrwrap_r0", rdata_v[0], 32'hAAAA0001);
        check("incrwrap_r1", rdata_v[1], 32'hBBBB0002);
        check("incrwrap_last0", 32'(rlast_v[0]), 32'd0);
        check("incrwrap_last1", 32'(rlast_v[1]), 32'd1);
        axi_read(6'h00, 8'd0, 3'd2, 2'd1, 1'b0, 1'b0);
        check("incrwrap_word0", rdata_v[0], 32'hBBBB0002);

        // WRAP burst from 0x08, len 3: words 2,3,0,1
        for (int i = 0; i < 4; i++) wdata_v[i] = 32'(i + 1);
        axi_write(6'h08, 8'd3, 3'd2, 2'd2, 1'b0, 1'b0, bresp);
        check("wrap_bresp", 32'(bresp), 32'd0);
        axi_read(6'h00, 8'd3, 3'd2, 2'd1, 1'b0, 1'b0);
        check("wrap_word0", rdata_v[0], 32'd3);
        check("wrap_word1", rdata_v[1], 32'd4);
        check("wrap_word2", rdata_v[2], 32'd1);
        check("wrap_word3", rdata_v[3], 32'd2);
        axi_read(6'h08, 8'd3, 3'd2, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check("wrap_read", rdata_v[i], 32'(i + 1));
        check("wrap_last", 32'(rlast_v[3]), 32'd1);

        // strobes and FIXED burst
        wdata_v[0] = 32'hFFFFFFFF;
        axi_write(6'h10, 8'd0, 3'd2, 2'd1, 1'b0, 1'b0, bresp);
        wdata_v[0] = 32'h000000AA; wstrb_v[0] = 4'h1;
        wdata_v[1] = 32'h0000BB00; wstrb_v[1] = 4'h2;
        axi_write(6'h10, 8'd1, 3'd2, 2'd0, 1'b1, 1'b0, bresp);
        check("fixed_bresp", 32'(bresp), 32'd0);
        wstrb_v[0] = 4'hF; wstrb_v[1] = 4'hF;
        axi_read(6'h10, 8'd0, 3'd2, 2'd1, 1'b0, 1'b0);
        check("strobe_rdata", rdata_v[0], 32'hFFFFBBAA);

        // size 3 write is rejected
        wdata_v[0] = 32'h12345678;
        axi_write(6'h10, 8'd0, 3'd3, 2'd1, 1'b0, 1'b0, bresp);
        check("size3_bresp", 32'(bresp), 32'd1);
        axi_read(6'h10, 8'd0, 3'd2, 2'd1, 1'b0, 1'b0);
        check("size3_unchanged", rdata_v[0], 32'hFFFFBBAA);

        // WRAP read with illegal len 2
        axi_read(6'h00, 8'd2, 3'd2, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("badwrap_data", rdata_v[i], 32'd0);
            check("badwrap_resp", 32'(rresp_v[i]), 32'd1);
            check("badwrap_last", 32'(rlast_v[i]), (i == 2) ? 32'd1 : 32'd0);
        end

        // early W_LAST
        wdata_v[0] = 32'h11111111; wdata_v[1] = 32'h22222222;
        axi_write(6'h20, 8'd1, 3'd2, 2'd1, 1'b1, 1'b1, bresp);
        check("early_last_bresp", 32'(bresp), 32'd1);
        axi_read(6'h20, 8'd1, 3'd2, 2'd1, 1'b0, 1'b0);
        check("early_last_w0", rdata_v[0], 32'd0);
        check("early_last_w1", rdata_v[1], 32'd0);

        // read backpressure
        for (int i = 0; i < 4; i++) wdata_v[i] = 32'hC0 + 32'(i);
        axi_write(6'h30, 8'd3, 3'd2, 2'd1, 1'b0, 1'b0, bresp);
        axi_read(6'h30, 8'd3, 3'd2, 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("bp_data", rdata_v[i], 32'hC0 + 32'(i));
            check("bp_last", 32'(rlast_v[i]), (i == 3) ? 32'd1 : 32'd0);
        end

        // reset during beat 2 of a write
        io_AW_ADDR = 6'h00; io_AW_LEN = 8'd3; io_AW_SIZE = 3'd2; io_AW_BURST = 2'd1;
        io_AW_ID = 1'b1; io_AW_VALID = 1'b1;
        step();
        io_AW_VALID = 1'b0;
        io_W_STRB = 4'hF; io_W_LAST = 1'b0; io_W_VALID = 1'b1;
        io_W_DATA = 32'h55555555;
        step();
        io_W_DATA = 32'h66666666;
        step();
        io_W_DATA = 32'h77777777;
        reset = 1'b1;
        step();
        io_W_VALID = 1'b0;
        check_reset_outputs("rst1");
        reset = 1'b0;
        step();
        axi_read(6'h00, 8'd0, 3'd2, 2'd1, 1'b0, 1'b0);
        check("post_reset_word0", rdata_v[0], 32'd0);
        axi_read(6'h30, 8'd0, 3'd2, 2'd1, 1'b0, 1'b0);
        check("post_reset_word12", rdata_v[0], 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 full-protocol memory responder with independent write (AW/W/B) and read (AR/R) engines, backing a 2^(ADDR_WIDTH-2)-word register array. It is the slave end of the `Top` AXI master and connects port-for-port to its io_AW/W/B/AR/R signals. It supports FIXED, INCR and WRAP bursts, byte strobes, and the sizes 1, 2 and 4 bytes. It returns error responses for illegal requests and does not hang on them.

## Interface
- ADDR_WIDTH, 6: byte address width; memory depth = 2^(ADDR_WIDTH-2) words (16).
- DATA_WIDTH, 32: data width; fixed at 32 (4 strobe bits).
- ID_WIDTH, 1: transaction ID width.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- io_AW_ADDR  in  ADDR_WIDTH  write start byte address.
- io_AW_LEN  in  8  beats-1.
- io_AW_SIZE  in  3  log2 bytes/beat.
- io_AW_BURST  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- io_AW_ID  in  ID_WIDTH  write ID.
- io_AW_PROT  in  3  ignored.
- io_AW_VALID  in  1; io_AW_READY  out  1.
- io_W_DATA  in  32; io_W_STRB  in  4; io_W_LAST  in  1; io_W_VALID  in  1; io_W_READY  out  1.
- io_B_ID  out  ID_WIDTH; io_B_RESP  out  1 (0 OKAY, 1 SLVERR); io_B_VALID  out  1; io_B_READY  in  1.
- io_AR_ADDR, io_AR_LEN, io_AR_SIZE, io_AR_BURST, io_AR_ID, io_AR_PROT, io_AR_VALID  in: same widths and meanings as the AW channel.
- io_AR_READY  out  1.
- io_R_DATA  out  32; io_R_ID  out  ID_WIDTH; io_R_RESP  out  1; io_R_LAST  out  1; io_R_VALID  out  1; io_R_READY  in  1.

## Operation
- **Write FSM** states are WIDLE, WDATA and WRESP.
  - WIDLE: io_AW_READY=1. On AW handshake, latch addr, len, size, burst and ID; clear beat counter and error flag; go to WDATA.
  - WDATA: io_W_READY=1. Each W handshake writes the byte lanes with STRB=1 into mem[addr[ADDR_WIDTH-1:2]], then advances addr and counter.
  - Leave WDATA for WRESP on the beat where counter==len.
  - WRESP: io_B_VALID=1 with latched ID and resp; return to WIDLE on B_READY.
- **Read FSM** states are RIDLE and RDATA.
  - RIDLE: io_AR_READY=1. On AR handshake, latch the request and load io_R_DATA with mem[start word]; go to RDATA.
  - RDATA: io_R_VALID=1, io_R_LAST=(counter==len). On R handshake, advance addr and counter and load the next word. On the last handshake, return to RIDLE.
- **Address update**, step = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr+step, modulo 2^ADDR_WIDTH (wraps 63→0).
  - WRAP: boundary = (len+1)*step. The next address is aligned base | ((addr+step) mod boundary).
- **Error (SLVERR) conditions**, sticky per burst:
  - size>2.
  - burst==3.
  - WRAP with len not in {1,3,7,15}.
  - WRAP with an unaligned start address.
  - Write only: W_LAST disagreeing with (counter==len) on any beat.
- **Effect of an error**:
  - Error writes perform no memory update.
  - Error reads return data 0 with R_RESP=1 on every beat.
  - Beat count still follows len, so the handshake always completes.
- The two engines run concurrently. If the same word is written and loaded into io_R_DATA in the same cycle, the read returns the pre-write value.

## Timing
- Reset, checked on the clock edge:
  - Both FSMs go to idle and the memory clears to 0.
  - Reset values: io_AW_READY=1, io_AR_READY=1. io_W_READY, io_B_VALID, io_B_RESP, io_B_ID, io_R_VALID, io_R_LAST, io_R_RESP, io_R_ID and io_R_DATA are all 0.
  - Reset mid-burst abandons the burst with no response; writes already performed before reset are also cleared.
- AW handshake in cycle N → io_W_READY=1 from cycle N+1; io_AW_READY=0 from N+1 until back in WIDLE.
- A W beat accepted in cycle N is visible to reads loaded from cycle N+1.
- Last W beat in cycle N → io_B_VALID=1 at N+1; it holds, with stable ID and resp, until B_READY.
- AR handshake in cycle N → io_R_VALID=1 with beat 0 data at N+1.
- Read throughput is one beat per cycle with R_READY held high.
- R outputs hold stable while R_VALID=1 and R_READY=0.
- W_VALID arriving while in WIDLE is not accepted, because W_READY=0.
- AW and AR handshakes in the same cycle are both accepted.

## Test plan
- **Single write, then read:**
  - Stimulus: AW addr 0x38, len 0, size 2, INCR, id 1; W data 0x07563314, strb 0xF, last 1.
  - Response: B resp 0, id 1, one cycle after W. Then AR 0x38 len 0 returns R_DATA 0x07563314, RLAST=1, resp 0.
- **INCR wrap-around:**
  - Stimulus: write addr 0x3C, len 1, size 2, data A then B.
  - Response: mem[15]=A, mem[0]=B. Read of the same burst returns A, B, with RLAST on beat 1.
- **WRAP burst:**
  - Stimulus: write addr 0x08, len 3, size 2, data 1,2,3,4.
  - Response: words 2,3,0,1 hold 1,2,3,4. Read of the same burst returns 1,2,3,4.
- **Strobes and FIXED burst:**
  - Stimulus: write 0xFFFFFFFF to 0x10, then FIXED len 1 to 0x10 with (0x000000AA, strb 0x1) and (0x0000BB00, strb 0x2).
  - Response: readback 0xFFFFBBAA.
- **Error cases** (each must leave the FSM back in idle):
  - Write with size 3 → B resp 1 and memory unchanged.
  - Read with WRAP len 2 → 3 beats of 0 with resp 1 and RLAST on beat 2.
  - Write with W_LAST asserted early → resp 1.
- **Backpressure and reset:**
  - Stimulus: read len 3 with R_READY toggled 1,0,0,1,…; then reset asserted during beat 2 of a write.
  - Response: read data holds while stalled and beats are neither lost nor duplicated. After the reset, all outputs take their reset values and a subsequent read returns 0.
